// File: rtl/uart_pkg.sv
// Shared UART types and constants: transmitter state encoding and data-length codes.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [1:0] UART_DBITS_5 = 2'd0;
  localparam logic [1:0] UART_DBITS_6 = 2'd1;
  localparam logic [1:0] UART_DBITS_7 = 2'd2;
  localparam logic [1:0] UART_DBITS_8 = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Index of the final data bit for a given length code (5 bits -> 4 ... 8 bits -> 7).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] dbits);
    return 3'(dbits) + 3'd4;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time generator: one-cycle tick every i_div+1 clocks, restartable via i_clear.
module uart_baud_gen #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_nrst,
  input  logic         i_clear,
  input  logic [W-1:0] i_div,
  output logic         o_tick
);

  logic [W-1:0] cnt;

  assign o_tick = (cnt == i_div);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      cnt <= '0;
    end else if (i_clear || o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from a FWFT FIFO and serialises them as
// start / 5-8 data (LSB first) / optional parity / 1-2 stop bit frames.
//
//   state  | meaning
//   IDLE   | line high, waiting for enable and a valid FIFO word
//   START  | start bit (line low) for one bit time
//   DATA   | shifting data bits out, LSB first
//   PARITY | parity bit over the transmitted data bits
//   STOP   | one or two stop bits (line high); may chain straight into START
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV_W = 16,
  parameter int DATA_W     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_enable,
  input  logic [BAUD_DIV_W-1:0] i_baud_div,
  input  logic [1:0]            i_data_bits,
  input  logic                  i_parity_en,
  input  logic                  i_parity_odd,
  input  logic                  i_stop2,
  input  logic                  i_fifo_valid,
  input  logic [DATA_W-1:0]     i_fifo_data,
  output logic                  o_fifo_rd_req,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_tx_done
);

  tx_state_t                  state, state_nx;
  logic [UART_DATA_W-1:0]     shreg, shreg_nx;
  logic                       par, par_nx;
  logic                       tx_nx;
  logic [2:0]                 bit_cnt;
  logic                       stop_cnt;
  logic [BAUD_DIV_W-1:0]      lat_div;
  logic [1:0]                 lat_dbits;
  logic                       lat_par_en, lat_odd, lat_stop2;
  logic                       tick, baud_clear, frame_end, can_pop;

  // Gated by reset so no pop strobe is offered while the flops cannot take the word.
  assign can_pop    = i_enable && i_fifo_valid && i_nrst;
  assign frame_end  = (state == STOP) && tick && (stop_cnt == lat_stop2);
  assign baud_clear = (state_nx != state) || (state == IDLE);
  assign o_busy     = (state != IDLE);

  uart_baud_gen #(.W(BAUD_DIV_W)) u_baud_gen (
    .i_clk   (i_clk),
    .i_nrst  (i_nrst),
    .i_clear (baud_clear),
    .i_div   (lat_div),
    .o_tick  (tick)
  );

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state      <= IDLE;
      shreg      <= '0;
      par        <= 1'b0;
      o_tx       <= 1'b1;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      lat_div    <= '0;
      lat_dbits  <= UART_DBITS_8;
      lat_par_en <= 1'b0;
      lat_odd    <= 1'b0;
      lat_stop2  <= 1'b0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      par   <= par_nx;
      o_tx  <= tx_nx;
      if (o_fifo_rd_req) begin
        lat_div    <= i_baud_div;
        lat_dbits  <= i_data_bits;
        lat_par_en <= i_parity_en;
        lat_odd    <= i_parity_odd;
        lat_stop2  <= i_stop2;
      end
      if (state_nx != state) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
      end else begin
        if (state == DATA && tick) bit_cnt <= bit_cnt + 3'd1;
        if (state == STOP && tick) stop_cnt <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (can_pop) state_nx = START;
      START:   if (tick) state_nx = DATA;
      DATA: begin
        if (tick && bit_cnt == last_bit_idx(lat_dbits))
          state_nx = lat_par_en ? PARITY : STOP;
      end
      PARITY:  if (tick) state_nx = STOP;
      STOP:    if (frame_end) state_nx = can_pop ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Line value is computed for the state being entered so o_tx can be registered.
  always_comb begin
    o_fifo_rd_req = ((state == IDLE) || frame_end) && can_pop;
    o_tx_done     = frame_end;
    shreg_nx      = shreg;
    par_nx        = par;
    if (o_fifo_rd_req) begin
      shreg_nx = i_fifo_data[UART_DATA_W-1:0];
      par_nx   = 1'b0;
    end else if (state == DATA && tick) begin
      shreg_nx = shreg >> 1;
      par_nx   = par ^ shreg[0];
    end
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shreg_nx[0];
      PARITY:  tx_nx = par_nx ^ lat_odd;
      default: tx_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a FIFO model feeds bytes, a per-clock frame
// scoreboard holds the expected line/done values and is drained while busy.
module tb_uart_tx;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic        enable;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic        parity_en, parity_odd, stop2;
  logic        fifo_valid = 1'b0;
  logic [7:0]  fifo_data = 8'h00;
  logic        rd_req, tx, busy, tx_done;

  uart_tx #(.BAUD_DIV_W(16), .DATA_W(8)) dut (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .i_enable     (enable),
    .i_baud_div   (baud_div),
    .i_data_bits  (data_bits),
    .i_parity_en  (parity_en),
    .i_parity_odd (parity_odd),
    .i_stop2      (stop2),
    .i_fifo_valid (fifo_valid),
    .i_fifo_data  (fifo_data),
    .o_fifo_rd_req(rd_req),
    .o_tx         (tx),
    .o_busy       (busy),
    .o_tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         busy_cyc;
  logic       rd_seen = 1'b0;
  logic [7:0] fifo_q[$];
  logic [1:0] exp_q[$];   // {tx, done} per clock
  int         pop_cyc[$];
  int         done_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: scoreboard check on the falling edge, FIFO model update after the rising edge.
  task automatic step(input int n);
    logic [1:0] e;
    repeat (n) begin
      @(negedge clk);
      cyc++;
      rd_seen = rd_req;
      if (nrst) begin
        if (rd_req) begin
          pop_cyc.push_back(cyc);
          check("rd_req_without_valid", fifo_valid, 1);
        end
        if (tx_done) done_cyc.push_back(cyc);
        if (busy) begin
          busy_cyc++;
          if (exp_q.size() == 0) check("busy_unexpected", busy, 0);
          else begin
            e = exp_q.pop_front();
            check("tx_line", tx, e[1]);
            check("tx_done", tx_done, e[0]);
          end
        end else begin
          check("idle_line", tx, 1);
          check("idle_done", tx_done, 0);
        end
      end
      @(posedge clk);
      #1;
      if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
      fifo_valid = (fifo_q.size() > 0);
      fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
      #1;
    end
  endtask

  task automatic expect_frame(input logic [7:0] d);
    logic b[$];
    logic p;
    logic dn;
    int   nd;
    p  = 1'b0;
    nd = 5 + int'(data_bits);
    b.push_back(1'b0);
    for (int i = 0; i < nd; i++) begin
      b.push_back(d[i]);
      p = p ^ d[i];
    end
    if (parity_en) b.push_back(p ^ parity_odd);
    b.push_back(1'b1);
    if (stop2) b.push_back(1'b1);
    for (int i = 0; i < b.size(); i++)
      for (int k = 0; k <= int'(baud_div); k++) begin
        dn = (i == b.size() - 1) && (k == int'(baud_div));
        exp_q.push_back({b[i], dn});
      end
  endtask

  task automatic push_byte(input logic [7:0] d);
    expect_frame(d);
    fifo_q.push_back(d);
  endtask

  task automatic clear_logs();
    pop_cyc.delete();
    done_cyc.delete();
    busy_cyc = 0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    step(1);
    while ((busy || exp_q.size() > 0 || fifo_q.size() > 0) && n < max) begin
      step(1);
      n++;
    end
    check("wait_idle_budget", (n < max), 1);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic wait_busy(input int max);
    int n;
    n = 0;
    while (!busy && n < max) begin
      step(1);
      n++;
    end
    check("busy_start", busy, 1);
  endtask

  task automatic check_frame_len(input string tag, input int len);
    if (pop_cyc.size() > 0 && done_cyc.size() > 0)
      check(tag, done_cyc[0] - pop_cyc[0], len);
    else
      check({tag, "_missing"}, done_cyc.size(), 1);
  endtask

  initial begin
    nrst       = 1'b0;
    enable     = 1'b0;
    baud_div   = 16'd3;
    data_bits  = UART_DBITS_8;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;
    step(3);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_done", tx_done, 0);
    nrst = 1'b1;
    step(2);

    // 8N1, div=3, 0x55
    clear_logs();
    enable = 1'b1;
    push_byte(8'h55);
    wait_idle(100);
    check("8n1_pops", pop_cyc.size(), 1);
    check("8n1_dones", done_cyc.size(), 1);
    check_frame_len("8n1_done_clk", 40);
    check("8n1_busy_cycles", busy_cyc, 40);

    // 7E2, div=0, 0xFF: bit 7 ignored
    clear_logs();
    baud_div = 16'd0; data_bits = UART_DBITS_7; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1;
    push_byte(8'hFF);
    wait_idle(50);
    check_frame_len("7e2_len", 11);
    check("7e2_busy_cycles", busy_cyc, 11);

    // 8O1 / 8E1 with 0x00
    clear_logs();
    data_bits = UART_DBITS_8; stop2 = 1'b0; parity_odd = 1'b1;
    push_byte(8'h00);
    wait_idle(50);
    check_frame_len("8o1_len", 11);
    clear_logs();
    parity_odd = 1'b0;
    push_byte(8'h00);
    wait_idle(50);
    check_frame_len("8e1_len", 11);

    // 5N1 div=2 and 6O2 div=1: upper bits ignored
    clear_logs();
    baud_div = 16'd2; data_bits = UART_DBITS_5; parity_en = 1'b0;
    push_byte(8'hE3);
    wait_idle(60);
    check_frame_len("5n1_len", 21);
    clear_logs();
    baud_div = 16'd1; data_bits = UART_DBITS_6; parity_en = 1'b1; parity_odd = 1'b1; stop2 = 1'b1;
    push_byte(8'hEA);
    wait_idle(60);
    check_frame_len("6o2_len", 20);

    // Back-to-back 8N1, div=1
    clear_logs();
    data_bits = UART_DBITS_8; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    push_byte(8'hA5);
    push_byte(8'h3C);
    wait_idle(100);
    check("b2b_pops", pop_cyc.size(), 2);
    check("b2b_dones", done_cyc.size(), 2);
    if (pop_cyc.size() == 2 && done_cyc.size() == 2) begin
      check("b2b_done1_clk", done_cyc[0] - pop_cyc[0], 20);
      check("b2b_done2_clk", done_cyc[1] - pop_cyc[0], 40);
      check("b2b_pop2_clk", pop_cyc[1] - pop_cyc[0], 20);
    end
    check("b2b_busy_cycles", busy_cyc, 40);

    // Disabled with data waiting: no pop
    clear_logs();
    enable = 1'b0;
    push_byte(8'h12);
    step(20);
    check("dis_pops", pop_cyc.size(), 0);
    check("dis_fifo_level", fifo_q.size(), 1);
    check("dis_line", tx, 1);

    // Enable, then drop it (and change config) mid-DATA: frame completes, no further pop
    enable = 1'b1;
    wait_busy(20);
    step(6);
    check("mid_in_frame", busy, 1);
    enable = 1'b0;
    data_bits = UART_DBITS_5; parity_en = 1'b1;
    fifo_q.push_back(8'h34);
    wait_idle_frame: begin
      int n;
      n = 0;
      while ((busy || exp_q.size() > 0) && n < 100) begin
        step(1);
        n++;
      end
      check("mid_frame_budget", (n < 100), 1);
    end
    step(10);
    check("mid_pops", pop_cyc.size(), 1);
    check("mid_fifo_level", fifo_q.size(), 1);
    check("mid_busy", busy, 0);
    check_frame_len("mid_len", 20);

    // Reset during DATA: line idle at once, byte lost, next byte clean
    baud_div = 16'd3; data_bits = UART_DBITS_8; parity_en = 1'b0;
    expect_frame(8'h34);
    enable = 1'b1;
    wait_busy(20);
    step(8);
    check("rst_mid_busy_before", busy, 1);
    nrst = 1'b0;
    #1;
    check("rst_mid_tx", tx, 1);
    check("rst_mid_busy", busy, 0);
    exp_q.delete();
    step(3);
    nrst = 1'b1;
    step(2);
    check("rst_mid_fifo_level", fifo_q.size(), 0);
    check("rst_mid_idle", busy, 0);
    clear_logs();
    push_byte(8'hC3);
    wait_idle(100);
    check("post_rst_pops", pop_cyc.size(), 1);
    check_frame_len("post_rst_len", 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter. Pops bytes from the downstream FIFO (first-word-fall-through) and drives them onto o_tx as UART frames.
- Frame order: start bit, 5–8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Instantiated in uart_top at the "Tranceiver INST" slot. Its clock is i_apb_pclk; its configuration comes from REGMAP control fields.
- Feeds the IRQ_TX_DONE event and tx_status.

Parameters:
- BAUD_DIV_W, 16: width of the baud divisor.
- DATA_W, 8: FIFO data width consumed. Only bits [7:0] are used.

Ports:
- i_clk  in  1  system clock (i_apb_pclk).
- i_nrst  in  1  asynchronous active-low reset.
- i_enable  in  1  transmitter enable.
- i_baud_div  in  BAUD_DIV_W  clocks per bit minus 1.
- i_data_bits  in  2  data length: 0=5, 1=6, 2=7, 3=8 bits.
- i_parity_en  in  1  insert a parity bit.
- i_parity_odd  in  1  1=odd parity, 0=even parity.
- i_stop2  in  1  1=two stop bits, 0=one stop bit.
- i_fifo_valid  in  1  FIFO head word valid (FWFT).
- i_fifo_data  in  DATA_W  FIFO head word.
- o_fifo_rd_req  out  1  one-cycle pop strobe.
- o_tx  out  1  serial line, registered output.
- o_busy  out  1  frame in progress (tx_status).
- o_tx_done  out  1  one-cycle pulse at end of each frame.

Behaviour:
- Reset values: o_tx=1, o_busy=0, o_fifo_rd_req=0, o_tx_done=0, FSM=IDLE, counters=0. Reset is asynchronous. Reset asserted mid-frame forces the line idle-high immediately and discards the frame; the popped byte is lost.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Baud tick:
  - Counter runs 0..i_baud_div. One bit time is i_baud_div+1 clocks.
  - Counter clears on every state entry.
  - i_baud_div=0 gives 1 clock per bit and must work.
- IDLE:
  - If i_enable && i_fifo_valid: assert o_fifo_rd_req combinationally for exactly that cycle, latch i_fifo_data into the shift register, latch all config inputs, go to START.
  - Otherwise o_fifo_rd_req=0.
- Config latching: config inputs are sampled only at a pop. Changes mid-frame do not affect the current frame.
- START: o_tx=0 for one bit time. The line goes low the cycle after the pop (registered output, latency 1). Then go to DATA.
- DATA:
  - Shift out LSB first; data bit count = latched length (5..8).
  - Parity is accumulated over the transmitted bits only.
  - After the last data bit: go to PARITY if parity is enabled, otherwise STOP.
- PARITY:
  - Even: o_tx = XOR of the data bits.
  - Odd: o_tx = inverted XOR of the data bits.
  - Lasts one bit time.
- STOP:
  - o_tx=1 for 1 or 2 bit times.
  - On the final clock of the last stop bit, o_tx_done pulses for 1 cycle.
  - In that same cycle, if i_enable && i_fifo_valid: pop and go directly to START. Back-to-back frames have no idle gap.
  - Otherwise go to IDLE.
- o_busy: 1 in every state except IDLE.
- Frame length: (1 + D + P + S) × (i_baud_div + 1) clocks, where D is data bits, P is 0/1 parity, S is 1/2 stop bits.
- i_enable deasserted mid-frame: the current frame completes normally; no further pops.
- i_fifo_valid low: never pop. o_fifo_rd_req is never asserted while i_fifo_valid=0, so no underflow is possible.
- Data bits above the latched length are ignored.

Decomposition:
- Additions to uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - Data-length encoding constants (UART_DBITS_5..8).
  - UART_DATA_W=8.
- One sub-module: uart_baud_gen. It is a clear-able counter producing a one-cycle tick every i_baud_div+1 clocks, and it will be reused by uart_rx.
- The FSM, shift register and parity logic stay in uart_tx.

Test Plan:
- 8N1, div=3, FIFO holds 0x55:
  - rd_req pulses once.
  - o_tx holds 1 for the cycle after reset, then 0 (start) for 4 clocks, then 1,0,1,0,1,0,1,0 (4 clocks each), then 1 for 4 clocks.
  - tx_done fires on clock 40.
- 7 data bits, even parity, 2 stop, div=0, data 0xFF:
  - Data bits 1111111, parity 1, stop bits 1,1; bit 7 ignored.
  - Frame is 11 clocks; busy high for all 11.
- Odd parity, 8 data bits, data 0x00: parity bit is 1. Same frame with even parity: parity bit is 0.
- Two bytes 0xA5, 0x3C queued, 8N1, div=1:
  - Second start bit immediately follows the first frame's stop bit, with no idle cycle.
  - Exactly 2 rd_req pulses; tx_done pulses at clocks 20 and 40.
- Enable handling:
  - i_enable=0 with i_fifo_valid=1 → no rd_req, o_tx=1.
  - Enable dropped mid-DATA → frame completes, then IDLE with no further pop.
- Reset asserted during DATA → o_tx=1 and busy=0 asynchronously. After release, the next valid byte transmits cleanly.
